// File: rtl/ir_packet_sequencer.sv
// IR remote packet scheduler: periodic launch, per-colour region FSM and carrier gating onto IR_LED.
// CARRIER_DIV divides the carrier period (1 in silicon; larger values shorten simulation).
module ir_packet_sequencer #(
  parameter int unsigned PKT_PERIOD  = 5000000,
  parameter bit          GAP_EN      = 1'b1,
  parameter int unsigned CARRIER_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COLOUR_SEL,
  input  logic [3:0] COMMAND,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       PKT_DONE
);

  localparam int unsigned PW = (PKT_PERIOD > 1) ? $clog2(PKT_PERIOD) : 1;
  localparam int unsigned CW = 11;
  localparam int unsigned RW = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_CARSEL = 3'd2;
  localparam logic [2:0] S_RIGHT  = 3'd3;
  localparam logic [2:0] S_LEFT   = 3'd4;
  localparam logic [2:0] S_BACK   = 3'd5;
  localparam logic [2:0] S_FWD    = 3'd6;
  localparam logic [2:0] S_GAP    = 3'd7;

  // Per-colour tables, index 0 = blue, 1 = yellow, 2 = green, 3 = red
  localparam logic [3:0][CW-1:0] CAR_P     = {11'd1389, 11'd1333, 11'd1250, 11'd1389};
  localparam logic [3:0][RW-1:0] START_LEN = {8'd192, 8'd88, 8'd88, 8'd191};
  localparam logic [3:0][RW-1:0] GAP_LEN   = {8'd24, 8'd40, 8'd40, 8'd25};
  localparam logic [3:0][RW-1:0] CSEL_LEN  = {8'd24, 8'd44, 8'd22, 8'd47};
  localparam logic [3:0][RW-1:0] ASRT_LEN  = {8'd48, 8'd44, 8'd44, 8'd47};
  localparam logic [3:0][RW-1:0] DASRT_LEN = {8'd24, 8'd22, 8'd22, 8'd22};

  logic [PW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [2:0]    gap_idx_q, gap_idx_d;
  logic [1:0]    colour_q, colour_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [CW-1:0] car_q, car_d;
  logic [RW-1:0] reg_q, reg_d;
  logic          ir_led_q, ir_led_d;
  logic          busy_q, busy_d;
  logic          pkt_done_q, pkt_done_d;

  logic          tick_c;
  logic [1:0]    colour_enc_c;
  logic [CW-1:0] per_c;
  logic [CW-1:0] per_next_c;
  logic          wrap_c;
  logic [RW-1:0] len_c;
  logic          last_c;

  always_comb begin
    cnt_d  = (cnt_q == PW'(PKT_PERIOD - 1)) ? '0 : cnt_q + PW'(1);
    tick_c = (cnt_d == PW'(PKT_PERIOD - 1));

    if (COLOUR_SEL[0])      colour_enc_c = 2'd0;
    else if (COLOUR_SEL[1]) colour_enc_c = 2'd1;
    else if (COLOUR_SEL[2]) colour_enc_c = 2'd2;
    else                    colour_enc_c = 2'd3;

    per_c  = CW'(32'(CAR_P[colour_q]) / CARRIER_DIV);
    wrap_c = (car_q == per_c - CW'(1));

    case (state_q)
      S_START:  len_c = START_LEN[colour_q];
      S_GAP:    len_c = GAP_LEN[colour_q];
      S_CARSEL: len_c = CSEL_LEN[colour_q];
      S_RIGHT:  len_c = cmd_q[3] ? ASRT_LEN[colour_q] : DASRT_LEN[colour_q];
      S_LEFT:   len_c = cmd_q[2] ? ASRT_LEN[colour_q] : DASRT_LEN[colour_q];
      S_BACK:   len_c = cmd_q[1] ? ASRT_LEN[colour_q] : DASRT_LEN[colour_q];
      S_FWD:    len_c = cmd_q[0] ? ASRT_LEN[colour_q] : DASRT_LEN[colour_q];
      default:  len_c = RW'(1);
    endcase
    last_c = wrap_c && (reg_q == len_c - RW'(1));
  end

  // Region sequencing: bursts advance through a gap (when enabled) tagged with the preceding burst
  always_comb begin
    state_d    = state_q;
    gap_idx_d  = gap_idx_q;
    colour_d   = colour_q;
    cmd_d      = cmd_q;
    car_d      = car_q;
    reg_d      = reg_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;

    if (state_q == S_IDLE) begin
      car_d = '0;
      reg_d = '0;
      if (tick_c && (COLOUR_SEL != 4'd0)) begin
        colour_d = colour_enc_c;
        cmd_d    = COMMAND;
        state_d  = S_START;
        busy_d   = 1'b1;
      end
    end else begin
      car_d = wrap_c ? '0 : car_q + CW'(1);
      if (wrap_c) reg_d = reg_q + RW'(1);
      if (last_c) begin
        reg_d = '0;
        if (state_q == S_GAP) begin
          if (gap_idx_q == S_FWD) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            pkt_done_d = 1'b1;
          end else begin
            state_d = gap_idx_q + 3'd1;
          end
        end else if (GAP_EN) begin
          state_d   = S_GAP;
          gap_idx_d = state_q;
        end else if (state_q == S_FWD) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          pkt_done_d = 1'b1;
        end else begin
          state_d = state_q + 3'd1;
        end
      end
    end

    // LED follows the carrier of the region entered on this edge
    per_next_c = CW'(32'(CAR_P[colour_d]) / CARRIER_DIV);
    ir_led_d   = (state_d != S_IDLE) && (state_d != S_GAP) &&
                 (car_d < (per_next_c >> 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      gap_idx_q  <= S_IDLE;
      colour_q   <= 2'd0;
      cmd_q      <= 4'd0;
      car_q      <= '0;
      reg_q      <= '0;
      ir_led_q   <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      gap_idx_q  <= gap_idx_d;
      colour_q   <= colour_d;
      cmd_q      <= cmd_d;
      car_q      <= car_d;
      reg_q      <= reg_d;
      ir_led_q   <= ir_led_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign IR_LED   = ir_led_q;
  assign BUSY     = busy_q;
  assign PKT_DONE = pkt_done_q;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Directed bench for ir_packet_sequencer: launch timing, packet lengths, carrier duty, latching, reset, gapless mode.
module tb_ir_packet_sequencer;

  localparam int unsigned PERIOD = 3000;
  localparam int unsigned DIV    = 128;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] colour_sel = 4'd0;
  logic [3:0] command = 4'd0;
  logic [3:0] colour_sel_ng = 4'd0;
  logic [3:0] command_ng = 4'd0;
  logic       ir_led, busy, pkt_done;
  logic       ir_led_ng, busy_ng, pkt_done_ng;
  logic       mon_sel = 1'b0;
  logic       m_led, m_busy, m_done;
  int         edge_n = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 CLK = ~CLK;

  ir_packet_sequencer #(.PKT_PERIOD(PERIOD), .GAP_EN(1'b1), .CARRIER_DIV(DIV)) u_dut (
    .CLK(CLK), .RST(RST), .COLOUR_SEL(colour_sel), .COMMAND(command),
    .IR_LED(ir_led), .BUSY(busy), .PKT_DONE(pkt_done)
  );

  ir_packet_sequencer #(.PKT_PERIOD(PERIOD), .GAP_EN(1'b0), .CARRIER_DIV(DIV)) u_ng (
    .CLK(CLK), .RST(RST), .COLOUR_SEL(colour_sel_ng), .COMMAND(command_ng),
    .IR_LED(ir_led_ng), .BUSY(busy_ng), .PKT_DONE(pkt_done_ng)
  );

  assign m_led  = mon_sel ? ir_led_ng   : ir_led;
  assign m_busy = mon_sel ? busy_ng     : busy;
  assign m_done = mon_sel ? pkt_done_ng : pkt_done;

  // Edges since the last edge that sampled RST high
  always @(posedge CLK) edge_n <= RST ? 0 : edge_n + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input int budget, output int at_edge, output int dones);
    int n;
    n = 0;
    dones = 0;
    at_edge = -1;
    while (!m_busy && n < budget) begin
      if (m_done) dones++;
      @(negedge CLK);
      n++;
    end
    if (m_busy) at_edge = edge_n;
  endtask

  // Called at the first sample with BUSY high; returns at a negedge a few cycles after BUSY falls
  task automatic measure_packet(output int len, output int hi, output int lo,
                                output int max_lo, output int dones);
    int run;
    int phase;
    len = 0; hi = 0; lo = 0; max_lo = 0; dones = 0; run = 0; phase = 0;
    while (m_busy && len < 20000) begin
      len++;
      if (m_done) dones++;
      if (phase == 0) begin
        if (m_led) hi++;
        else begin phase = 1; lo = 1; end
      end else if (phase == 1) begin
        if (!m_led) lo++;
        else phase = 2;
      end
      if (!m_led) begin
        run++;
        if (run > max_lo) max_lo = run;
      end else begin
        run = 0;
      end
      @(negedge CLK);
    end
    repeat (4) begin
      if (m_done) dones++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int le, dn, len, hi, lo, mlo, viol;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_ir_led", int'(ir_led), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_pkt_done", int'(pkt_done), 0);
    RST = 1'b0;

    // Yellow, forward only: P=9, H=4, 460 periods
    colour_sel = 4'b0010;
    command    = 4'b0001;
    wait_busy(3200, le, dn);
    check_eq("yel_launch_edge", le, 2999);
    check_eq("yel_led_at_launch", int'(ir_led), 1);
    measure_packet(len, hi, lo, mlo, dn);
    check_eq("yel_len", len, 4140);
    check_eq("yel_high", hi, 4);
    check_eq("yel_low", lo, 5);
    check_eq("yel_done_pulses", dn, 1);

    // Blue wins over yellow; mid-packet switch to red must not disturb it
    colour_sel = 4'b0011;
    command    = 4'b0000;
    wait_busy(3200, le, dn);
    check_eq("blue_launch_after_overrun", le, 8999);
    fork
      begin
        repeat (300) @(negedge CLK);
        colour_sel = 4'b1000;
        command    = 4'b1111;
      end
    join_none
    measure_packet(len, hi, lo, mlo, dn);
    check_eq("blue_len", len, 4760);
    check_eq("blue_high", hi, 5);
    check_eq("blue_done_pulses", dn, 1);

    // Red with all directions asserted, picked up only at the next launch
    wait_busy(3200, le, dn);
    check_eq("red_launch_edge", le, 14999);
    measure_packet(len, hi, lo, mlo, dn);
    check_eq("red_len", len, 5520);
    check_eq("red_done_pulses", dn, 1);

    // No colour selected across a tick
    colour_sel = 4'b0000;
    command    = 4'b0000;
    viol = 0;
    while (edge_n < 21200) begin
      if (busy || ir_led || pkt_done) viol++;
      @(negedge CLK);
    end
    check_eq("idle_no_packet", viol, 0);
    colour_sel = 4'b0100;
    wait_busy(3200, le, dn);
    check_eq("green_launch_edge", le, 23999);
    measure_packet(len, hi, lo, mlo, dn);
    check_eq("green_len", len, 4600);
    check_eq("green_high", hi, 5);
    check_eq("green_low", lo, 5);

    // Reset during CARSEL (offset 1280..1719 of the green packet)
    wait_busy(3200, le, dn);
    check_eq("green2_launch_edge", le, 29999);
    repeat (1400) @(negedge CLK);
    RST = 1'b1;
    colour_sel_ng = 4'b1000;
    command_ng    = 4'b1111;
    @(negedge CLK);
    check_eq("rst_ir_led", int'(ir_led), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_pkt_done", int'(pkt_done), 0);
    RST = 1'b0;
    wait_busy(3200, le, dn);
    check_eq("post_rst_launch_edge", le, 2999);
    check_eq("post_rst_no_done", dn, 0);
    check_eq("ng_launch_same_edge", int'(busy_ng), 1);

    // Gapless red, 1111: 408 periods with no low run beyond P-H
    mon_sel = 1'b1;
    measure_packet(len, hi, lo, mlo, dn);
    check_eq("ng_len", len, 4080);
    check_eq("ng_high", hi, 5);
    check_eq("ng_max_low_run", mlo, 5);
    check_eq("ng_done_pulses", dn, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
